// File: rtl/frame_fifo_sync.sv
// -----------------------------------------------------------------------------
// frame_fifo_sync
//
// Single-clock frame FIFO for the ADC sample path. Conversion results arrive
// one word at a time (RESULT qualified by DONE, channel given one-hot on
// CHSEL). They are assembled in a staging register, and the whole NCH-word
// frame plus its channel-valid mask is committed on DONE & LASTWORD. Up to
// FRAME_DEPTH frames are buffered. The head frame is presented registered on
// ADC_data / FRAME_CHMASK / FRAME_VALID.
//
// Ports
//   HF_CLK          clock, all logic on the rising edge
//   NRST_sync       asynchronous active-low reset
//   ENSAMP_sync     synchronous enable; low clears pointers, staging and head
//   RESULT          conversion result (DW bits)
//   DONE            one-cycle strobe, RESULT valid
//   CHSEL           one-hot channel of RESULT (lowest set bit wins, 0 = drop)
//   LASTWORD        with DONE: commit the frame including this word
//   FIFO_POP        one-cycle pop strobe
//   OVWR_MODE       full-FIFO policy: 0 drop newest, 1 overwrite oldest
//   FIFOWATERMARK   DATA_RDY threshold in frames
//   ADC_data        head frame, channel k at [k*DW +: DW]
//   FRAME_CHMASK    channels written in the head frame
//   FRAME_VALID     ADC_data / FRAME_CHMASK hold a real frame
//   FRAME_COUNT     stored frames, 0..FRAME_DEPTH
//   DATA_RDY        FRAME_COUNT >= FIFOWATERMARK while enabled
//   FIFO_OVERFLOW   toggles once per lost frame
//   FIFO_UNDERFLOW  toggles once per pop on an empty FIFO
//   DROP_COUNT      saturating count of lost frames
// -----------------------------------------------------------------------------
module frame_fifo_sync #(
  parameter int NCH         = 8,
  parameter int DW          = 16,
  parameter int FRAME_DEPTH = 16,
  parameter int CW          = $clog2(FRAME_DEPTH) + 1
) (
  input  logic                HF_CLK,
  input  logic                NRST_sync,
  input  logic                ENSAMP_sync,
  input  logic [DW-1:0]       RESULT,
  input  logic                DONE,
  input  logic [NCH-1:0]      CHSEL,
  input  logic                LASTWORD,
  input  logic                FIFO_POP,
  input  logic                OVWR_MODE,
  input  logic [CW-1:0]       FIFOWATERMARK,
  output logic [NCH*DW-1:0]   ADC_data,
  output logic [NCH-1:0]      FRAME_CHMASK,
  output logic                FRAME_VALID,
  output logic [CW-1:0]       FRAME_COUNT,
  output logic                DATA_RDY,
  output logic                FIFO_OVERFLOW,
  output logic                FIFO_UNDERFLOW,
  output logic [7:0]          DROP_COUNT
);

  localparam int AW = CW - 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FRAME_DEPTH);

  typedef logic [NCH-1:0][DW-1:0] frame_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Index of the lowest set bit; callers qualify with |v.
  function automatic logic [IW-1:0] low_idx(input logic [NCH-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  frame_t           stage_q;
  logic [NCH-1:0]   smask_q;
  frame_t           mem_data [FRAME_DEPTH];
  logic [NCH-1:0]   mem_mask [FRAME_DEPTH];
  logic [CW-1:0]    wr_q;
  logic [CW-1:0]    rd_q;

  // ---------------------------------------------------------------------------
  // Word decode and frame assembly
  // ---------------------------------------------------------------------------
  logic             word_hit;
  logic [IW-1:0]    word_idx;
  logic [NCH-1:0]   word_sel;
  frame_t           frame_merged;
  logic [NCH-1:0]   mask_merged;

  always_comb begin
    word_hit = |CHSEL;
    word_idx = low_idx(CHSEL);
    word_sel = '0;
    if (word_hit) word_sel[word_idx] = 1'b1;
    // The staged frame with the current word folded in; this is both the next
    // staging value and the frame image written on commit.
    frame_merged = stage_q;
    for (int k = 0; k < NCH; k++) begin
      if (word_sel[k]) frame_merged[k] = RESULT;
    end
    mask_merged = smask_q | word_sel;
  end

  // ---------------------------------------------------------------------------
  // Pointer / event decode
  // ---------------------------------------------------------------------------
  logic             word_wr;
  logic             commit;
  logic             pop_req;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             pop_under;
  logic             commit_lost;
  logic             commit_store;
  logic             rd_adv;

  always_comb begin
    word_wr   = ENSAMP_sync & DONE;
    commit    = word_wr & LASTWORD;
    pop_req   = ENSAMP_sync & FIFO_POP;
    count     = wr_q - rd_q;
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    // The pop is judged against the pre-edge count, so a pop on a full FIFO
    // makes room for a same-cycle commit and no frame is lost.
    pop_ok    = pop_req & ~empty;
    pop_under = pop_req & empty;
    commit_lost  = commit & full & ~pop_ok;
    // In overwrite mode a lost commit still stores; the oldest frame is the
    // one that disappears, by advancing rd together with wr.
    commit_store = commit & ~(commit_lost & ~OVWR_MODE);
    rd_adv       = pop_ok | (commit_lost & OVWR_MODE);
  end

  // ---------------------------------------------------------------------------
  // Staging register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      stage_q <= '0;
      smask_q <= '0;
    end else if (!ENSAMP_sync || commit) begin
      stage_q <= '0;
      smask_q <= '0;
    end else if (word_wr) begin
      stage_q <= frame_merged;
      smask_q <= mask_merged;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame memory and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      for (int i = 0; i < FRAME_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_mask[i] <= '0;
      end
    end else if (commit_store) begin
      mem_data[wr_q[AW-1:0]] <= frame_merged;
      mem_mask[wr_q[AW-1:0]] <= mask_merged;
    end
  end

  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (!ENSAMP_sync) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (commit_store) wr_q <= wr_q + 1'b1;
      if (rd_adv)       rd_q <= rd_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Head-frame output register, loaded from the current (post-previous-edge)
  // pointer state, hence one cycle behind a commit or pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      ADC_data     <= '0;
      FRAME_CHMASK <= '0;
      FRAME_VALID  <= 1'b0;
    end else if (!ENSAMP_sync || empty) begin
      ADC_data     <= '0;
      FRAME_CHMASK <= '0;
      FRAME_VALID  <= 1'b0;
    end else begin
      ADC_data     <= mem_data[rd_q[AW-1:0]];
      FRAME_CHMASK <= mem_mask[rd_q[AW-1:0]];
      FRAME_VALID  <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Event toggles and lost-frame counter; these survive ENSAMP_sync low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      FIFO_OVERFLOW  <= 1'b0;
      FIFO_UNDERFLOW <= 1'b0;
      DROP_COUNT     <= '0;
    end else begin
      if (pop_under) FIFO_UNDERFLOW <= ~FIFO_UNDERFLOW;
      if (commit_lost) begin
        FIFO_OVERFLOW <= ~FIFO_OVERFLOW;
        DROP_COUNT    <= sat_inc8(DROP_COUNT);
      end
    end
  end

  assign FRAME_COUNT = count;
  assign DATA_RDY    = ENSAMP_sync & (count >= FIFOWATERMARK);

endmodule

// File: tb/tb_frame_fifo_sync.sv
// -----------------------------------------------------------------------------
// tb_frame_fifo_sync
//
// Directed self-checking bench for frame_fifo_sync with default parameters
// (NCH=8, DW=16, FRAME_DEPTH=16, CW=5). Inputs change 1 ns after the rising
// edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_frame_fifo_sync;

  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int FD  = 16;
  localparam int CW  = 5;

  logic              HF_CLK;
  logic              NRST_sync;
  logic              ENSAMP_sync;
  logic [DW-1:0]     RESULT;
  logic              DONE;
  logic [NCH-1:0]    CHSEL;
  logic              LASTWORD;
  logic              FIFO_POP;
  logic              OVWR_MODE;
  logic [CW-1:0]     FIFOWATERMARK;
  logic [NCH*DW-1:0] ADC_data;
  logic [NCH-1:0]    FRAME_CHMASK;
  logic              FRAME_VALID;
  logic [CW-1:0]     FRAME_COUNT;
  logic              DATA_RDY;
  logic              FIFO_OVERFLOW;
  logic              FIFO_UNDERFLOW;
  logic [7:0]        DROP_COUNT;

  int checks   = 0;
  int failures = 0;

  frame_fifo_sync #(.NCH(NCH), .DW(DW), .FRAME_DEPTH(FD)) dut (
    .HF_CLK        (HF_CLK),
    .NRST_sync     (NRST_sync),
    .ENSAMP_sync   (ENSAMP_sync),
    .RESULT        (RESULT),
    .DONE          (DONE),
    .CHSEL         (CHSEL),
    .LASTWORD      (LASTWORD),
    .FIFO_POP      (FIFO_POP),
    .OVWR_MODE     (OVWR_MODE),
    .FIFOWATERMARK (FIFOWATERMARK),
    .ADC_data      (ADC_data),
    .FRAME_CHMASK  (FRAME_CHMASK),
    .FRAME_VALID   (FRAME_VALID),
    .FRAME_COUNT   (FRAME_COUNT),
    .DATA_RDY      (DATA_RDY),
    .FIFO_OVERFLOW (FIFO_OVERFLOW),
    .FIFO_UNDERFLOW(FIFO_UNDERFLOW),
    .DROP_COUNT    (DROP_COUNT)
  );

  initial HF_CLK = 1'b0;
  always #5 HF_CLK = ~HF_CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HF_CLK);
    #1;
  endtask

  // One DONE strobe on channel ch (ch<0 means CHSEL==0), optional pop.
  task automatic send(input int ch, input logic [15:0] d, input logic last, input logic pop);
    DONE     = 1'b1;
    CHSEL    = (ch < 0) ? 8'h00 : 8'(1 << ch);
    RESULT   = d;
    LASTWORD = last;
    FIFO_POP = pop;
    tick();
    DONE     = 1'b0;
    CHSEL    = 8'h00;
    LASTWORD = 1'b0;
    FIFO_POP = 1'b0;
  endtask

  task automatic do_pop();
    FIFO_POP = 1'b1;
    tick();
    FIFO_POP = 1'b0;
  endtask

  task automatic clear_fifo();
    ENSAMP_sync = 1'b0;
    tick();
    ENSAMP_sync = 1'b1;
  endtask

  initial begin
    NRST_sync     = 1'b0;
    ENSAMP_sync   = 1'b0;
    RESULT        = '0;
    DONE          = 1'b0;
    CHSEL         = '0;
    LASTWORD      = 1'b0;
    FIFO_POP      = 1'b0;
    OVWR_MODE     = 1'b0;
    FIFOWATERMARK = '0;
    tick();
    tick();

    // Reset state
    check("rst_data",  ADC_data, 128'h0);
    check("rst_mask",  FRAME_CHMASK, 8'h00);
    check("rst_valid", FRAME_VALID, 1'b0);
    check("rst_count", FRAME_COUNT, 5'd0);
    check("rst_rdy",   DATA_RDY, 1'b0);
    check("rst_ovf",   FIFO_OVERFLOW, 1'b0);
    check("rst_unf",   FIFO_UNDERFLOW, 1'b0);
    check("rst_drop",  DROP_COUNT, 8'd0);

    NRST_sync = 1'b1;
    tick();
    ENSAMP_sync = 1'b1;
    #1;
    check("wm0_rdy", DATA_RDY, 1'b1);

    // Full eight-channel frame
    for (int k = 0; k < 8; k++) send(k, 16'h1000 + 16'(k), (k == 7), 1'b0);
    check("f1_count", FRAME_COUNT, 5'd1);
    check("f1_valid_lat", FRAME_VALID, 1'b0);
    tick();
    check("f1_data",  ADC_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    check("f1_mask",  FRAME_CHMASK, 8'hFF);
    check("f1_valid", FRAME_VALID, 1'b1);
    do_pop();
    check("f1_pop_count", FRAME_COUNT, 5'd0);
    tick();
    check("f1_pop_valid", FRAME_VALID, 1'b0);
    check("f1_pop_data",  ADC_data, 128'h0);

    // Single-channel frame
    send(2, 16'hBEEF, 1'b1, 1'b0);
    tick();
    check("f2_data", ADC_data, 128'h0000_0000_0000_0000_0000_BEEF_0000_0000);
    check("f2_mask", FRAME_CHMASK, 8'h04);
    do_pop();
    tick();

    // Drop-newest overflow
    OVWR_MODE = 1'b0;
    for (int t = 1; t <= 17; t++) send(0, 16'(t), 1'b1, 1'b0);
    check("dn_count", FRAME_COUNT, 5'd16);
    check("dn_ovf",   FIFO_OVERFLOW, 1'b1);
    check("dn_drop",  DROP_COUNT, 8'd1);
    for (int t = 1; t <= 16; t++) begin
      tick();
      check("dn_valid", FRAME_VALID, 1'b1);
      check("dn_tag",   ADC_data[15:0], 16'(t));
      do_pop();
    end
    check("dn_empty", FRAME_COUNT, 5'd0);
    do_pop();
    check("dn_unf",   FIFO_UNDERFLOW, 1'b1);
    check("dn_unf_count", FRAME_COUNT, 5'd0);

    // Overwrite-oldest overflow
    OVWR_MODE = 1'b1;
    for (int t = 1; t <= 17; t++) send(0, 16'(t), 1'b1, 1'b0);
    check("ow_count", FRAME_COUNT, 5'd16);
    check("ow_ovf",   FIFO_OVERFLOW, 1'b0);
    check("ow_drop",  DROP_COUNT, 8'd2);
    for (int t = 2; t <= 17; t++) begin
      tick();
      check("ow_tag", ADC_data[15:0], 16'(t));
      do_pop();
    end
    check("ow_empty", FRAME_COUNT, 5'd0);

    // Simultaneous commit and pop on full, then on empty
    OVWR_MODE = 1'b0;
    for (int t = 1; t <= 16; t++) send(0, 16'(t), 1'b1, 1'b0);
    send(0, 16'd17, 1'b1, 1'b1);
    check("cp_full_count", FRAME_COUNT, 5'd16);
    check("cp_full_ovf",   FIFO_OVERFLOW, 1'b0);
    check("cp_full_drop",  DROP_COUNT, 8'd2);
    tick();
    check("cp_full_head",  ADC_data[15:0], 16'd2);
    clear_fifo();
    send(0, 16'h0033, 1'b1, 1'b1);
    check("cp_empty_unf",   FIFO_UNDERFLOW, 1'b0);
    check("cp_empty_count", FRAME_COUNT, 5'd1);
    tick();
    check("cp_empty_head",  ADC_data[15:0], 16'h0033);

    // Watermark, disable mid-frame, no stale staging
    clear_fifo();
    FIFOWATERMARK = 5'd4;
    #1;
    check("wm_rdy0", DATA_RDY, 1'b0);
    for (int t = 1; t <= 3; t++) send(1, 16'(t), 1'b1, 1'b0);
    check("wm_rdy3", DATA_RDY, 1'b0);
    send(1, 16'd4, 1'b1, 1'b0);
    check("wm_rdy4", DATA_RDY, 1'b1);
    send(1, 16'hAAAA, 1'b0, 1'b0);
    ENSAMP_sync = 1'b0;
    tick();
    check("dis_count", FRAME_COUNT, 5'd0);
    check("dis_valid", FRAME_VALID, 1'b0);
    check("dis_rdy",   DATA_RDY, 1'b0);
    check("dis_drop",  DROP_COUNT, 8'd2);
    check("dis_ovf",   FIFO_OVERFLOW, 1'b0);
    check("dis_unf",   FIFO_UNDERFLOW, 1'b0);
    ENSAMP_sync = 1'b1;
    send(3, 16'h5555, 1'b1, 1'b0);
    tick();
    check("re_data", ADC_data, 128'h0000_0000_0000_0000_5555_0000_0000_0000);
    check("re_mask", FRAME_CHMASK, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
